mult_div_unit: RTL



---
 rtl/mult_div_unit_pkg.sv | 25 ++
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit_cond_neg.sv | 13 +
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: operation
// codes, FSM state encodings and the counter-width helper.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] ZDIV = 2'd3;

    // Ceiling log2; wide enough for an iteration counter holding WIDTH-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide unit handshake and operand/result bus.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_cond_neg.sv
// Combinational conditional two's-complement negate.
module mdu_cond_neg #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         neg_i,
    output logic [W-1:0] value_o
);
    // Pass through or negate.
    always_comb begin
        value_o = neg_i ? ('0 - value_i) : value_i;
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit owning the HI/LO pair. Operates on
// magnitudes (shift-add multiply, restoring divide), one bit per cycle,
// and applies the result signs in a final fix-up cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    import mdu_pkg::*;

    localparam int unsigned CW = clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               in_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] wide_in, wide_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign in_signed = ~bus.op[0];

    mdu_cond_neg #(.W(WIDTH)) u_abs_a (
        .value_i (bus.a),
        .neg_i   (in_signed & bus.a[WIDTH-1]),
        .value_o (mag_a)
    );

    mdu_cond_neg #(.W(WIDTH)) u_abs_b (
        .value_i (bus.b),
        .neg_i   (in_signed & bus.b[WIDTH-1]),
        .value_o (mag_b)
    );

    // Divide only needs the low half negated by the quotient sign, so the
    // wide instance sees a zero-extended quotient and serves both cases.
    assign wide_in = op_q[1] ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

    mdu_cond_neg #(.W(2*WIDTH)) u_fix_wide (
        .value_i (wide_in),
        .neg_i   (neg_lo_q),
        .value_o (wide_fix)
    );

    mdu_cond_neg #(.W(WIDTH)) u_fix_rem (
        .value_i (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i   (neg_hi_q),
        .value_o (rem_fix)
    );

    // One iteration step: shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mb_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    neg_lo_d = in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_hi_d = in_signed & bus.a[WIDTH-1];
                    cnt_d    = CW'(WIDTH - 1);
                    if (bus.op[1]) begin
                        mb_d  = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                        state_d = (bus.b == '0) ? ZDIV : RUN;
                    end else begin
                        mb_d  = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = op_q[1] ? rem_fix : wide_fix[2*WIDTH-1:WIDTH];
                lo_d    = wide_fix[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ZDIV: begin
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy     = (state_q == RUN) || (state_q == FIX);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
